// File: rtl/pwm_axi_multi.sv
// Multi-channel PWM with an AXI4-Lite register bank. All channels share one
// prescaler and period counter; PERIOD/DUTY are shadowed and load at the period wrap.
module pwm_axi_multi #(
    parameter int NUM_CH             = 4,
    parameter int CNT_W              = 16,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [NUM_CH-1:0]               pwm_o,
    output logic                            irq_o
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int IW = AW - 2;

    // AXI handshake state
    logic        awready_q, awready_d;
    logic        bvalid_q, bvalid_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;

    // Register bank
    logic              run_q, run_d;
    logic              irq_en_q, irq_en_d;
    logic [NUM_CH-1:0] ch_en_q, ch_en_d;
    logic [NUM_CH-1:0] pol_q, pol_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  prescale_q, prescale_d;
    logic              status_q, status_d;
    logic [CNT_W-1:0]  duty_q [NUM_CH];
    logic [CNT_W-1:0]  duty_d [NUM_CH];

    // PWM core state
    logic [CNT_W-1:0]  pcnt_q, pcnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  period_act_q, period_act_d;
    logic [CNT_W-1:0]  duty_act_q [NUM_CH];
    logic [CNT_W-1:0]  duty_act_d [NUM_CH];
    logic [NUM_CH-1:0] pwm_q, pwm_d;

    logic          wr_en;
    logic [IW-1:0] widx, ridx;
    logic [31:0]   wmask;
    logic [31:0]   ctrl_rd;
    logic [31:0]   rd_mux;
    logic          tick, wrap;
    logic          unused_bits;

    function automatic logic [CNT_W-1:0] merge_cnt(input logic [CNT_W-1:0] old_v,
                                                    input logic [CNT_W-1:0] new_v,
                                                    input logic [CNT_W-1:0] m);
        return (old_v & ~m) | (new_v & m);
    endfunction

    assign widx  = S_AXI_AWADDR[AW-1:2];
    assign ridx  = S_AXI_ARADDR[AW-1:2];
    assign wr_en = awready_q;

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            wmask[8*b +: 8] = {8{S_AXI_WSTRB[b]}};
        end
    end

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                           S_AXI_ARADDR[1:0], S_AXI_WDATA, wmask};

    always_comb begin
        ctrl_rd               = '0;
        ctrl_rd[0]            = run_q;
        ctrl_rd[1]            = irq_en_q;
        ctrl_rd[8 +: NUM_CH]  = ch_en_q;
        ctrl_rd[16 +: NUM_CH] = pol_q;
    end

    always_comb begin
        rd_mux = '0;
        case (ridx)
            IW'(0):  rd_mux = ctrl_rd;
            IW'(1):  rd_mux = 32'(period_q);
            IW'(2):  rd_mux = {31'b0, status_q};
            IW'(3):  rd_mux = 32'(prescale_q);
            default: rd_mux = '0;
        endcase
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (ridx == IW'(4 + ch)) begin
                rd_mux = 32'(duty_q[ch]);
            end
        end
    end

    always_comb begin
        awready_d = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~awready_q;
        bvalid_d  = awready_q | (bvalid_q & ~S_AXI_BREADY);
        arready_d = S_AXI_ARVALID & ~rvalid_q & ~arready_q;
        rvalid_d  = arready_q | (rvalid_q & ~S_AXI_RREADY);
        rdata_d   = arready_q ? rd_mux : rdata_q;
    end

    // Prescaler and period counter; >= keeps pcnt from running away if PRESCALE shrinks
    always_comb begin
        tick = run_q && (pcnt_q >= prescale_q);
        wrap = tick && (cnt_q >= period_act_q);
        pcnt_d       = '0;
        cnt_d        = '0;
        period_act_d = period_q;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            duty_act_d[ch] = duty_q[ch];
        end
        if (run_q) begin
            pcnt_d       = tick ? '0 : pcnt_q + 1'b1;
            cnt_d        = wrap ? '0 : (tick ? cnt_q + 1'b1 : cnt_q);
            period_act_d = wrap ? period_q : period_act_q;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                duty_act_d[ch] = wrap ? duty_q[ch] : duty_act_q[ch];
            end
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            pwm_d[ch] = (run_q & ch_en_q[ch] & (cnt_q < duty_act_q[ch])) ^ pol_q[ch];
        end
    end

    // Register writes; a wrap set on STATUS overrides a coincident W1C
    always_comb begin
        run_d      = run_q;
        irq_en_d   = irq_en_q;
        ch_en_d    = ch_en_q;
        pol_d      = pol_q;
        period_d   = period_q;
        prescale_d = prescale_q;
        status_d   = status_q;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            duty_d[ch] = duty_q[ch];
        end
        if (wr_en) begin
            case (widx)
                IW'(0): begin
                    run_d    = wmask[0] ? S_AXI_WDATA[0] : run_q;
                    irq_en_d = wmask[1] ? S_AXI_WDATA[1] : irq_en_q;
                    ch_en_d  = (ch_en_q & ~wmask[8 +: NUM_CH]) |
                               (S_AXI_WDATA[8 +: NUM_CH] & wmask[8 +: NUM_CH]);
                    pol_d    = (pol_q & ~wmask[16 +: NUM_CH]) |
                               (S_AXI_WDATA[16 +: NUM_CH] & wmask[16 +: NUM_CH]);
                end
                IW'(1): period_d = merge_cnt(period_q, S_AXI_WDATA[CNT_W-1:0], wmask[CNT_W-1:0]);
                IW'(2): if (S_AXI_WSTRB[0] && S_AXI_WDATA[0]) status_d = 1'b0;
                IW'(3): prescale_d = merge_cnt(prescale_q, S_AXI_WDATA[CNT_W-1:0], wmask[CNT_W-1:0]);
                default: ;
            endcase
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (widx == IW'(4 + ch)) begin
                    duty_d[ch] = merge_cnt(duty_q[ch], S_AXI_WDATA[CNT_W-1:0], wmask[CNT_W-1:0]);
                end
            end
        end
        if (wrap) begin
            status_d = 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            awready_q    <= 1'b0;
            bvalid_q     <= 1'b0;
            arready_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            run_q        <= 1'b0;
            irq_en_q     <= 1'b0;
            ch_en_q      <= '0;
            pol_q        <= '0;
            period_q     <= '0;
            prescale_q   <= '0;
            status_q     <= 1'b0;
            pcnt_q       <= '0;
            cnt_q        <= '0;
            period_act_q <= '0;
            pwm_q        <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                duty_q[ch]     <= '0;
                duty_act_q[ch] <= '0;
            end
        end else begin
            awready_q    <= awready_d;
            bvalid_q     <= bvalid_d;
            arready_q    <= arready_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            run_q        <= run_d;
            irq_en_q     <= irq_en_d;
            ch_en_q      <= ch_en_d;
            pol_q        <= pol_d;
            period_q     <= period_d;
            prescale_q   <= prescale_d;
            status_q     <= status_d;
            pcnt_q       <= pcnt_d;
            cnt_q        <= cnt_d;
            period_act_q <= period_act_d;
            pwm_q        <= pwm_d;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                duty_q[ch]     <= duty_d[ch];
                duty_act_q[ch] <= duty_act_d[ch];
            end
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign pwm_o         = pwm_q;
    assign irq_o         = status_q & irq_en_q;

endmodule

// File: tb/tb_pwm_axi_multi.sv
// Directed bench for pwm_axi_multi: register access, waveforms, shadow timing, interrupt, reset.
module tb_pwm_axi_multi;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [5:0]  AWADDR, ARADDR;
    logic [2:0]  AWPROT, ARPROT;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;
    logic [3:0]  pwm_o;
    logic        irq_o;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [1:0]  last_bresp, last_rresp;

    always #5 ACLK = ~ACLK;

    pwm_axi_multi #(.NUM_CH(4), .CNT_W(16), .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
        .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
        .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
        .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
        .pwm_o(pwm_o), .irq_o(irq_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit seen = 0;
        AWADDR = addr; WDATA = data; WSTRB = strb;
        AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (AWREADY && WREADY) begin seen = 1; break; end
        end
        if (!seen) begin
            check("aw_timeout", 0, 1);
            AWVALID = 1'b0; WVALID = 1'b0;
            return;
        end
        step();
        AWVALID = 1'b0; WVALID = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (BVALID) begin seen = 1; break; end
            step();
        end
        if (!seen) check("b_timeout", 0, 1);
        else last_bresp = BRESP;
        step();
    endtask

    task automatic axi_read(input logic [5:0] addr, output logic [31:0] data);
        bit seen = 0;
        data = '0;
        ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ARREADY) begin seen = 1; break; end
        end
        if (!seen) begin
            check("ar_timeout", 0, 1);
            ARVALID = 1'b0;
            return;
        end
        step();
        ARVALID = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (RVALID) begin seen = 1; break; end
            step();
        end
        if (!seen) check("r_timeout", 0, 1);
        else begin data = RDATA; last_rresp = RRESP; end
        step();
    endtask

    task automatic wr(input logic [5:0] addr, input logic [31:0] data);
        axi_write(addr, data, 4'hF);
    endtask

    task automatic find_edge(input logic want, output bit ok);
        logic prev, cur;
        prev = pwm_o[0];
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            cur = pwm_o[0];
            if (cur != prev && cur == want) begin ok = 1; break; end
            prev = cur;
        end
    endtask

    task automatic capture(input int n, output logic [31:0] v);
        v = '0;
        for (int i = 0; i < n; i++) begin
            step();
            v = {v[30:0], pwm_o[0]};
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, v;
        bit          ok, seen;
        logic        s [81];
        int          hi, per;

        ARESETN = 1'b0;
        AWADDR = '0; ARADDR = '0; AWPROT = '0; ARPROT = '0;
        AWVALID = 0; WVALID = 0; BREADY = 0; ARVALID = 0; RREADY = 0;
        WDATA = '0; WSTRB = '0;
        last_bresp = 2'b11; last_rresp = 2'b11;
        repeat (20) step();
        check("rst_handshake", {27'b0, AWREADY, WREADY, BVALID, ARREADY, RVALID}, 0);
        check("rst_rdata", RDATA, 0);
        check("rst_pwm", pwm_o, 0);
        check("rst_irq", irq_o, 0);
        ARESETN = 1'b1;
        step();
        for (int a = 0; a < 12; a++) begin
            axi_read(6'(4 * a), rd);
            check($sformatf("rst_reg_%0h", 4 * a), rd, 0);
        end
        check("rst_pwm_after", pwm_o, 0);
        check("rst_irq_after", irq_o, 0);

        // Register read/write
        wr(6'h04, 32'h9);
        for (int c = 0; c < 4; c++) wr(6'(8'h10 + 4 * c), 32'(c + 1));
        axi_read(6'h04, rd); check("rw_period", rd, 9);
        for (int c = 0; c < 4; c++) begin
            axi_read(6'(8'h10 + 4 * c), rd);
            check($sformatf("rw_duty%0d", c), rd, 32'(c + 1));
        end
        wr(6'h20, 32'hDEADBEEF);
        check("unmapped_bresp", 32'(last_bresp), 0);
        axi_read(6'h20, rd);
        check("unmapped_rd", rd, 0);
        check("unmapped_rresp", 32'(last_rresp), 0);
        wr(6'h04, 32'h1234);
        axi_write(6'h04, 32'hFFFF, 4'b0001);
        axi_read(6'h04, rd); check("wstrb_period", rd, 32'h12FF);
        wr(6'h00, 32'hFFFF_FFFF);
        axi_read(6'h00, rd); check("ctrl_mask", rd, 32'h000F_0F03);
        wr(6'h00, 32'h0);

        // Duty waveform
        wr(6'h0C, 0); wr(6'h04, 9); wr(6'h10, 3); wr(6'h00, 32'h101);
        find_edge(1'b1, ok); check("wave_rise_found", 32'(ok), 1);
        capture(19, v); v = v | (32'd1 << 19);
        check("wave_duty3", v, 32'b1110000000_1110000000);
        check("wave_other_ch", {28'b0, pwm_o[3:1]}, 0);
        wr(6'h00, 32'h10101);
        repeat (12) step();
        find_edge(1'b0, ok); check("pol_fall_found", 32'(ok), 1);
        capture(19, v);
        check("wave_pol", v, 32'b0001111111_0001111111);
        check("pol_other_ch", {28'b0, pwm_o[3:1]}, 0);

        // Boundaries
        wr(6'h00, 32'h101);
        wr(6'h10, 0);
        repeat (25) step();
        capture(20, v); check("duty0_low", v, 0);
        wr(6'h10, 10);
        repeat (25) step();
        capture(20, v); check("duty10_high", v, 32'hF_FFFF);
        wr(6'h10, 3); wr(6'h0C, 2);
        find_edge(1'b1, ok); check("presc_rise_found", 32'(ok), 1);
        s[0] = 1'b1;
        for (int i = 1; i < 81; i++) begin step(); s[i] = pwm_o[0]; end
        hi = 81;
        for (int i = 0; i < 81; i++) if (!s[i]) begin hi = i; break; end
        per = 0;
        for (int i = 1; i < 81; i++) if (!s[i-1] && s[i]) begin per = i; break; end
        check("presc_high_len", 32'(hi), 9);
        check("presc_period", 32'(per), 30);

        // Shadow update mid-period and in the wrap cycle
        wr(6'h0C, 0);
        repeat (40) step();
        find_edge(1'b1, ok); check("shadow_rise_found", 32'(ok), 1);
        repeat (2) step();
        wr(6'h10, 7);
        capture(14, v);
        check("shadow_mid", v, 32'b0000_1111111_000);
        find_edge(1'b1, ok); check("shadow_wrap_rise_found", 32'(ok), 1);
        repeat (7) step();
        wr(6'h10, 2);
        capture(14, v);
        check("shadow_at_wrap", v, 32'b111111_000_11_000);

        // Interrupt
        wr(6'h00, 0); wr(6'h04, 99); wr(6'h08, 1);
        axi_read(6'h08, rd); check("status_cleared", rd, 0);
        check("irq_idle", irq_o, 0);
        wr(6'h00, 32'h103);
        check("irq_before_wrap", irq_o, 0);
        seen = 0;
        for (int i = 0; i < 150; i++) begin step(); if (irq_o) begin seen = 1; break; end end
        check("irq_rise", 32'(seen), 1);
        wr(6'h08, 1);
        check("irq_w1c", irq_o, 0);
        axi_read(6'h08, rd); check("status_w1c", rd, 0);
        seen = 0;
        for (int i = 0; i < 150; i++) begin step(); if (irq_o) begin seen = 1; break; end end
        check("irq_rise2", 32'(seen), 1);
        repeat (98) step();
        wr(6'h08, 1);
        check("irq_w1c_at_wrap", irq_o, 1);
        axi_read(6'h08, rd); check("status_w1c_at_wrap", rd, 1);

        // Reset in the middle of outstanding responses
        AWADDR = 6'h24; WDATA = 32'h5; WSTRB = 4'hF; ARADDR = 6'h00;
        BREADY = 0; RREADY = 0; AWVALID = 1; WVALID = 1; ARVALID = 1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin step(); if (BVALID && RVALID) begin seen = 1; break; end end
        check("burst_vld", 32'(seen), 1);
        #2 ARESETN = 1'b0;
        #1;
        check("rst_mid_bvalid", BVALID, 0);
        check("rst_mid_rvalid", RVALID, 0);
        check("rst_mid_irq", irq_o, 0);
        check("rst_mid_pwm", pwm_o, 0);
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        repeat (3) step();
        ARESETN = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
